// File: rtl/reg32_load_clear.sv
// reg32_load_clear
//   Parallel-load data register with synchronous clear and asynchronous
//   active-low reset. Q is taken straight from the flops, so downstream
//   logic sees no combinational path from D, Load or clear.
//
// Parameters
//   WIDTH        data width of D and Q (>= 1)
//   RESET_VALUE  value loaded on rst_n assertion and on synchronous clear
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous reset, active-low
//   clear  in   1      synchronous clear, active-high, wins over Load
//   Load   in   1      load enable, active-high
//   D      in   WIDTH  data to store
//   Q      out  WIDTH  register contents
module reg32_load_clear #(
    parameter int unsigned            WIDTH       = 32,
    parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // clear is checked before Load so a simultaneous request resolves to
    // RESET_VALUE. With both low, D is never looked at, so an X on D
    // cannot leak into Q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q <= RESET_VALUE;
        end else if (clear) begin
            Q <= RESET_VALUE;
        end else if (Load) begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_reg32_load_clear.sv
// Testbench for reg32_load_clear (WIDTH=32, RESET_VALUE=0).
// Expected values are queued when stimulus is applied and popped after the
// edge at which the DUT should show them.
module tb_reg32_load_clear;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         clear = 1'b0;
    logic         Load  = 1'b0;
    logic [W-1:0] D     = '0;
    logic [W-1:0] Q;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;
    int           n_checks = 0;
    int           n_fail   = 0;

    reg32_load_clear #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .Load  (Load),
        .D     (D),
        .Q     (Q)
    );

    always #5 clk = ~clk;

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        D = 32'hFFFF_FFFF; Load = 1'b1; clear = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(32'h0000_0000);
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL reset_immediate: Q=%h expected %h", Q, exp);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0000_0000);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (Q !== exp) begin
                n_fail++; $display("FAIL reset_hold[%0d]: Q=%h expected %h", i, Q, exp);
            end
        end
        @(negedge clk);
        Load = 1'b0; rst_n = 1'b1;
        exp_q.push_back(32'h0000_0000);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL reset_release: Q=%h expected %h", Q, exp);
        end
    endtask

    task automatic test_basic_load();
        @(negedge clk);
        D = 32'hAAAA_AAAA; Load = 1'b1;
        exp_q.push_back(32'hAAAA_AAAA);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL basic_load: Q=%h expected %h", Q, exp);
        end
        @(negedge clk);
        Load = 1'b0; D = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hAAAA_AAAA);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (Q !== exp) begin
                n_fail++; $display("FAIL basic_hold[%0d]: Q=%h expected %h", i, Q, exp);
            end
        end
        // X on D with Load=0 must not disturb Q
        @(negedge clk);
        D = 'x;
        exp_q.push_back(32'hAAAA_AAAA);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL hold_x_d: Q=%h expected %h", Q, exp);
        end
    endtask

    task automatic test_consecutive();
        @(negedge clk);
        D = 32'h5555_5555; Load = 1'b1;
        exp_q.push_back(32'h5555_5555);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL consec_1: Q=%h expected %h", Q, exp);
        end
        @(negedge clk);
        D = 32'hA5A5_A5A5;
        exp_q.push_back(32'hA5A5_A5A5);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL consec_2: Q=%h expected %h", Q, exp);
        end
        @(negedge clk);
        Load = 1'b0;
    endtask

    task automatic test_sync_clear();
        // Q = A5A5A5A5 here
        clear = 1'b1;
        #1;
        n_checks++;
        if (Q !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL clear_not_early: Q=%h expected %h", Q, 32'hA5A5_A5A5);
        end
        exp_q.push_back(32'h0000_0000);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL sync_clear: Q=%h expected %h", Q, exp);
        end
        @(negedge clk);
        clear = 1'b0; D = 32'hA5A5_A5A5; Load = 1'b1;
        tick();
        @(negedge clk);
        Load = 1'b0;
        // clear pulse that starts and ends between edges
        #1 clear = 1'b1;
        #2 clear = 1'b0;
        exp_q.push_back(32'hA5A5_A5A5);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL clear_glitch: Q=%h expected %h", Q, exp);
        end
    endtask

    task automatic test_clear_vs_load();
        @(negedge clk);
        D = 32'h5A5A_5A5A; Load = 1'b1;
        exp_q.push_back(32'h5A5A_5A5A);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL cvl_preload: Q=%h expected %h", Q, exp);
        end
        @(negedge clk);
        clear = 1'b1; D = 32'h1234_5678;
        exp_q.push_back(32'h0000_0000);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL clear_vs_load: Q=%h expected %h", Q, exp);
        end
        @(negedge clk);
        clear = 1'b0; Load = 1'b0;
    endtask

    task automatic test_async_mid();
        @(negedge clk);
        D = 32'h5A5A_5A5A; Load = 1'b1;
        tick();
        @(negedge clk);
        // Load stays high while reset drops between edges
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(32'h0000_0000);
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL async_mid: Q=%h expected %h", Q, exp);
        end
        exp_q.push_back(32'h0000_0000);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL async_hold: Q=%h expected %h", Q, exp);
        end
        @(negedge clk);
        rst_n = 1'b1; D = 32'hDEAD_BEEF; Load = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (Q !== exp) begin
            n_fail++; $display("FAIL post_reset_load: Q=%h expected %h", Q, exp);
        end
        @(negedge clk);
        Load = 1'b0;
    endtask

    // random mix of clear/Load/D, expected value follows the priority rule
    task automatic test_back_to_back();
        logic [W-1:0] model;
        model = 32'hDEAD_BEEF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            clear = ($urandom_range(0, 4) == 0);
            Load  = $urandom_range(0, 1) == 1;
            D     = $urandom;
            if (clear)     model = 32'h0000_0000;
            else if (Load) model = D;
            exp_q.push_back(model);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (Q !== exp) begin
                n_fail++; $display("FAIL b2b[%0d]: Q=%h expected %h", i, Q, exp);
            end
        end
        @(negedge clk);
        clear = 1'b0; Load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_consecutive();
        test_sync_clear();
        test_clear_vs_load();
        test_async_mid();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule
